// File: rtl/motor_pkg.sv
// Shared codes for the motor drive controller: FSM modes, bridge direction encodings,
// tracker states and a duty clamp helper.
package motor_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE    = 3'd0,
    MODE_FWD     = 3'd1,
    MODE_STEER_L = 3'd2,
    MODE_STEER_R = 3'd3,
    MODE_SEARCH  = 3'd4,
    MODE_STOP    = 3'd5
  } mode_e;

  typedef enum logic {
    TURN_LEFT  = 1'b0,
    TURN_RIGHT = 1'b1
  } turn_e;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_COAST = 2'b00;

  localparam logic [1:0] TRACK_CENTRE = 2'b11;
  localparam logic [1:0] TRACK_VEER_R = 2'b10;
  localparam logic [1:0] TRACK_VEER_L = 2'b01;
  localparam logic [1:0] TRACK_LOST   = 2'b00;

  // Saturate a requested duty into the range a PWM counter of the given width can express.
  function automatic int clamp_duty(input int value, input int bits);
    int top_s;
    top_s = (32'sd1 <<< bits) - 32'sd1;
    if (value > top_s) return top_s;
    else if (value < 32'sd0) return 32'sd0;
    else return value;
  endfunction

endpackage

// File: rtl/motor_drive_ctrl_if.sv
// Signal bundle between the tracker stage / run control and the motor drive controller.
interface motor_drive_ctrl_if #(
  parameter int PWM_BITS = 10
) ();
  logic                enable;
  logic [1:0]          track_state;
  logic                pwm_l;
  logic                pwm_r;
  logic [1:0]          dir_l;
  logic [1:0]          dir_r;
  logic [2:0]          mode;
  logic [PWM_BITS-1:0] duty_l;
  logic [PWM_BITS-1:0] duty_r;

  modport master (
    output enable, track_state,
    input  pwm_l, pwm_r, dir_l, dir_r, mode, duty_l, duty_r
  );

  modport slave (
    input  enable, track_state,
    output pwm_l, pwm_r, dir_l, dir_r, mode, duty_l, duty_r
  );
endinterface

// File: rtl/pwm_channel.sv
// One motor channel: ramps duty toward its target on each ramp tick, latches the duty into
// the compare register only at counter wrap, and drives a registered PWM pin.
module pwm_channel import motor_pkg::*; #(
  parameter int PWM_BITS  = 10,
  parameter int RAMP_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] cnt_next,
  input  logic [PWM_BITS-1:0] target,
  output logic [PWM_BITS-1:0] duty,
  output logic                pwm
);
  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS + 1)'(clamp_duty(RAMP_STEP, PWM_BITS));

  logic [PWM_BITS-1:0] duty_r;
  logic [PWM_BITS-1:0] cmp_r;
  logic                pwm_r;
  logic [PWM_BITS-1:0] duty_next_s;
  logic [PWM_BITS-1:0] cmp_next_s;
  logic [PWM_BITS:0]   tgt_w_s;
  logic [PWM_BITS:0]   duty_w_s;
  logic [PWM_BITS:0]   gap_s;
  logic [PWM_BITS:0]   move_s;

  // Extended-width step toward target, limited so it lands on the target instead of passing it.
  always_comb begin
    tgt_w_s  = {1'b0, target};
    duty_w_s = {1'b0, duty_r};
    if (tgt_w_s >= duty_w_s) gap_s = tgt_w_s - duty_w_s;
    else gap_s = duty_w_s - tgt_w_s;
    if (gap_s > STEP_W) move_s = STEP_W;
    else move_s = gap_s;
    if (tgt_w_s >= duty_w_s) duty_next_s = PWM_BITS'(duty_w_s + move_s);
    else duty_next_s = PWM_BITS'(duty_w_s - move_s);
    if (wrap) cmp_next_s = duty_r;
    else cmp_next_s = cmp_r;
  end

  // Pin is computed from next-cycle counter/compare so it is registered yet has no lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r <= {PWM_BITS{1'b0}};
      cmp_r  <= {PWM_BITS{1'b0}};
      pwm_r  <= 1'b0;
    end else begin
      if (tick) duty_r <= duty_next_s;
      cmp_r <= cmp_next_s;
      pwm_r <= (cnt_next < cmp_next_s);
    end
  end

  assign duty = duty_r;
  assign pwm  = pwm_r;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Line-follower motor drive: filters the tracker state, runs the steering/search FSM,
// applies the decelerate-before-reverse rule and feeds two ramped PWM channels.
module motor_drive_ctrl import motor_pkg::*; #(
  parameter int PWM_BITS     = 10,
  parameter int FILT_N       = 8,
  parameter int RAMP_TICKS   = 100000,
  parameter int RAMP_STEP    = 16,
  parameter int DUTY_FAST    = 900,
  parameter int DUTY_SLOW    = 300,
  parameter int DUTY_SPIN    = 500,
  parameter int SEARCH_STEPS = 1500
) (
  input  logic              clk,
  input  logic              rst,
  motor_drive_ctrl_if.slave bus
);
  localparam int FILT_W = $clog2(FILT_N + 1);
  localparam int TICK_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam int SRCH_W = $clog2(SEARCH_STEPS + 1);
  localparam logic [PWM_BITS-1:0] T_FAST  = PWM_BITS'(clamp_duty(DUTY_FAST, PWM_BITS));
  localparam logic [PWM_BITS-1:0] T_SLOW  = PWM_BITS'(clamp_duty(DUTY_SLOW, PWM_BITS));
  localparam logic [PWM_BITS-1:0] T_SPIN  = PWM_BITS'(clamp_duty(DUTY_SPIN, PWM_BITS));
  localparam logic [PWM_BITS-1:0] T_ZERO  = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

  logic [1:0]          cand_r, accepted_r;
  logic [FILT_W-1:0]   filt_cnt_r;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic [PWM_BITS-1:0] pwm_cnt_r, pwm_cnt_next_s;
  logic [SRCH_W-1:0]   search_cnt_r;
  mode_e               mode_r;
  turn_e               last_turn_r;
  logic [1:0]          dir_l_r, dir_r_r, want_l_s, want_r_s;
  logic [PWM_BITS-1:0] base_l_s, base_r_s, tgt_l_s, tgt_r_s, duty_l_s, duty_r_s;
  logic                tick_s, wrap_s, pwm_l_s, pwm_r_s;

  assign tick_s         = (tick_cnt_r == TICK_W'(RAMP_TICKS - 1));
  assign wrap_s         = (pwm_cnt_r == CNT_MAX);
  assign pwm_cnt_next_s = pwm_cnt_r + PWM_BITS'(1);

  // Accept a new tracker state only after it has been seen FILT_N clocks in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_r     <= TRACK_CENTRE;
      filt_cnt_r <= {FILT_W{1'b0}};
      accepted_r <= TRACK_CENTRE;
    end else if (bus.track_state != cand_r) begin
      cand_r     <= bus.track_state;
      filt_cnt_r <= FILT_W'(1);
      if (FILT_N <= 1) accepted_r <= bus.track_state;
    end else begin
      if (filt_cnt_r < FILT_W'(FILT_N)) filt_cnt_r <= filt_cnt_r + FILT_W'(1);
      if (filt_cnt_r >= FILT_W'(FILT_N - 1)) accepted_r <= cand_r;
    end
  end

  // Free-running ramp tick divider and shared PWM counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      pwm_cnt_r  <= {PWM_BITS{1'b0}};
    end else begin
      tick_cnt_r <= tick_s ? {TICK_W{1'b0}} : tick_cnt_r + TICK_W'(1);
      pwm_cnt_r  <= pwm_cnt_next_s;
    end
  end

  // Mode FSM; dropping enable returns to IDLE from every state, and STOP is left only that way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r       <= MODE_IDLE;
      last_turn_r  <= TURN_LEFT;
      search_cnt_r <= {SRCH_W{1'b0}};
    end else if (!bus.enable) begin
      mode_r       <= MODE_IDLE;
      search_cnt_r <= {SRCH_W{1'b0}};
    end else begin
      case (mode_r)
        MODE_IDLE: if (accepted_r != TRACK_LOST) mode_r <= MODE_FWD;
        MODE_FWD, MODE_STEER_L, MODE_STEER_R: begin
          case (accepted_r)
            TRACK_CENTRE: mode_r <= MODE_FWD;
            TRACK_VEER_R: begin mode_r <= MODE_STEER_L; last_turn_r <= TURN_LEFT; end
            TRACK_VEER_L: begin mode_r <= MODE_STEER_R; last_turn_r <= TURN_RIGHT; end
            default: begin mode_r <= MODE_SEARCH; search_cnt_r <= {SRCH_W{1'b0}}; end
          endcase
        end
        MODE_SEARCH: begin
          if (accepted_r != TRACK_LOST) mode_r <= MODE_FWD;
          else if (tick_s) begin
            if (search_cnt_r == SRCH_W'(SEARCH_STEPS - 1)) mode_r <= MODE_STOP;
            else search_cnt_r <= search_cnt_r + SRCH_W'(1);
          end
        end
        MODE_STOP: mode_r <= MODE_STOP;
        default:   mode_r <= MODE_IDLE;
      endcase
    end
  end

  // Per-mode wheel plan; a wheel whose bridge must change direction is first driven to zero.
  always_comb begin
    want_l_s = DIR_COAST;
    want_r_s = DIR_COAST;
    base_l_s = T_ZERO;
    base_r_s = T_ZERO;
    case (mode_r)
      MODE_FWD:     begin want_l_s = DIR_FWD; want_r_s = DIR_FWD; base_l_s = T_FAST; base_r_s = T_FAST; end
      MODE_STEER_L: begin want_l_s = DIR_FWD; want_r_s = DIR_FWD; base_l_s = T_SLOW; base_r_s = T_FAST; end
      MODE_STEER_R: begin want_l_s = DIR_FWD; want_r_s = DIR_FWD; base_l_s = T_FAST; base_r_s = T_SLOW; end
      MODE_SEARCH: begin
        base_l_s = T_SPIN;
        base_r_s = T_SPIN;
        if (last_turn_r == TURN_LEFT) begin want_l_s = DIR_REV; want_r_s = DIR_FWD; end
        else begin want_l_s = DIR_FWD; want_r_s = DIR_REV; end
      end
      default: begin want_l_s = DIR_COAST; want_r_s = DIR_COAST; end
    endcase
    if (want_l_s != dir_l_r) tgt_l_s = T_ZERO;
    else tgt_l_s = base_l_s;
    if (want_r_s != dir_r_r) tgt_r_s = T_ZERO;
    else tgt_r_s = base_r_s;
  end

  // Bridge direction flips only once that wheel has spun down to zero duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_l_r <= DIR_COAST;
      dir_r_r <= DIR_COAST;
    end else begin
      if (want_l_s != dir_l_r && duty_l_s == T_ZERO) dir_l_r <= want_l_s;
      if (want_r_s != dir_r_r && duty_r_s == T_ZERO) dir_r_r <= want_r_s;
    end
  end

  pwm_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_left (
    .clk(clk), .rst(rst), .tick(tick_s), .wrap(wrap_s), .cnt_next(pwm_cnt_next_s),
    .target(tgt_l_s), .duty(duty_l_s), .pwm(pwm_l_s)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_right (
    .clk(clk), .rst(rst), .tick(tick_s), .wrap(wrap_s), .cnt_next(pwm_cnt_next_s),
    .target(tgt_r_s), .duty(duty_r_s), .pwm(pwm_r_s)
  );

  assign bus.mode   = mode_r;
  assign bus.dir_l  = dir_l_r;
  assign bus.dir_r  = dir_r_r;
  assign bus.duty_l = duty_l_s;
  assign bus.duty_r = duty_r_s;
  assign bus.pwm_l  = pwm_l_s;
  assign bus.pwm_r  = pwm_r_s;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Directed bench for motor_drive_ctrl: a cycle-level behavioural model is checked every clock,
// and hand-computed literals pin ramp sequences, PWM high time and mode transitions.
module tb_motor_drive_ctrl;
  localparam int PB = 6, MAXC = 63, FILT = 8, RT = 16, SS = 20, STEP = 8;
  localparam int FAST = 60, SLOW = 20, SPIN = 40;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   dq[$];

  motor_drive_ctrl_if #(.PWM_BITS(PB)) bus ();

  motor_drive_ctrl #(
    .PWM_BITS(PB), .FILT_N(FILT), .RAMP_TICKS(RT), .RAMP_STEP(STEP),
    .DUTY_FAST(FAST), .DUTY_SLOW(SLOW), .DUTY_SPIN(SPIN), .SEARCH_STEPS(SS)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_prev, m_run, m_acc, m_mode, m_last, m_scnt, m_tcnt, m_pcnt;
  int m_duty[2], m_cmp[2], m_dir[2];
  int base_tab[2][6] = '{'{0, FAST, SLOW, FAST, SPIN, 0}, '{0, FAST, FAST, SLOW, SPIN, 0}};

  function automatic int mode_for_track(input int t);
    case (t)
      3: return 1;
      2: return 2;
      1: return 3;
      default: return 4;
    endcase
  endfunction

  // wheel 0 = left, 1 = right; codes 2 fwd, 1 rev, 0 coast
  function automatic int want_dir(input int md, input int last, input int wheel);
    if (md >= 1 && md <= 3) return 2;
    if (md == 4) return ((last == 0) == (wheel == 0)) ? 1 : 2;
    return 0;
  endfunction

  function automatic int approach(input int d, input int t);
    if (t > d) return (t - d > STEP) ? d + STEP : t;
    return (d - t > STEP) ? d - STEP : t;
  endfunction

  task automatic model_reset();
    m_prev = 3; m_run = 0; m_acc = 3; m_mode = 0; m_last = 0; m_scnt = 0; m_tcnt = 0; m_pcnt = 0;
    for (int k = 0; k < 2; k++) begin m_duty[k] = 0; m_cmp[k] = 0; m_dir[k] = 0; end
  endtask

  task automatic model_step();
    int tick, raw, nrun, nacc, nmode, nlast, nscnt, w, t, nd, nc, ndir;
    raw   = int'(bus.track_state);
    tick  = (m_tcnt == RT - 1) ? 1 : 0;
    nrun  = (raw == m_prev) ? m_run + 1 : 1;
    nacc  = (nrun >= FILT) ? raw : m_acc;
    nmode = m_mode; nlast = m_last; nscnt = (m_mode == 4) ? m_scnt : 0;
    if (!bus.enable) nmode = 0;
    else if (m_mode == 0) nmode = (m_acc != 0) ? 1 : 0;
    else if (m_mode >= 1 && m_mode <= 3) nmode = mode_for_track(m_acc);
    else if (m_mode == 4) begin
      if (m_acc != 0) nmode = 1;
      else if (tick == 1) begin
        nscnt = m_scnt + 1;
        if (nscnt >= SS) nmode = 5;
      end
    end
    if (nmode == 2) nlast = 0;
    if (nmode == 3) nlast = 1;
    for (int k = 0; k < 2; k++) begin
      w    = want_dir(m_mode, m_last, k);
      t    = (w != m_dir[k]) ? 0 : base_tab[k][m_mode];
      nd   = (tick == 1) ? approach(m_duty[k], t) : m_duty[k];
      nc   = (m_pcnt == MAXC) ? m_duty[k] : m_cmp[k];
      ndir = (w != m_dir[k] && m_duty[k] == 0) ? w : m_dir[k];
      m_duty[k] = nd; m_cmp[k] = nc; m_dir[k] = ndir;
    end
    m_prev = raw; m_run = nrun; m_acc = nacc; m_mode = nmode; m_last = nlast; m_scnt = nscnt;
    m_tcnt = (tick == 1) ? 0 : m_tcnt + 1;
    m_pcnt = (m_pcnt + 1) % (MAXC + 1);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] dut_vec();
    return {bus.mode, bus.dir_l, bus.dir_r, bus.duty_l, bus.duty_r, bus.pwm_l, bus.pwm_r};
  endfunction

  // Every cycle out of reset: all outputs against the model.
  initial begin
    logic [20:0] exp_v;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        exp_v = {3'(m_mode), 2'(m_dir[0]), 2'(m_dir[1]), 6'(m_duty[0]), 6'(m_duty[1]),
                 (m_pcnt < m_cmp[0]), (m_pcnt < m_cmp[1])};
        checks++;
        if (dut_vec() !== exp_v) begin
          errors++;
          $display("FAIL model_cycle: got %h expected %h at %0t", dut_vec(), exp_v, $time);
        end
      end
    end
  end

  task automatic wait_mode(input int want, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(bus.mode) == want) break;
    end
    check(name, int'(bus.mode), want);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic collect_duty_l(input int n, input int budget);
    int prev;
    dq.delete();
    prev = int'(bus.duty_l);
    for (int i = 0; i < budget && dq.size() < n; i++) begin
      @(negedge clk);
      if (int'(bus.duty_l) != prev) begin
        prev = int'(bus.duty_l);
        dq.push_back(prev);
      end
    end
  endtask

  task automatic count_high(output int nl, output int nr);
    nl = 0; nr = 0;
    for (int i = 0; i < MAXC + 1; i++) begin
      @(negedge clk);
      if (bus.pwm_l) nl++;
      if (bus.pwm_r) nr++;
    end
  endtask

  int exp_up[8]   = '{8, 16, 24, 32, 40, 48, 56, 60};
  int exp_down[8] = '{52, 44, 36, 28, 20, 12, 4, 0};

  initial begin
    int nl, nr;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.track_state = 2'b11;
    idle_cycles(3);
    check("reset_state", int'(dut_vec()), 0);
    rst = 1'b0;

    // ramp up from idle to straight-line speed
    bus.enable = 1'b1;
    wait_mode(1, 10, "idle_to_fwd");
    collect_duty_l(8, 300);
    for (int i = 0; i < 8; i++) check("ramp_up_step", (i < dq.size()) ? dq[i] : -1, exp_up[i]);
    check("ramp_up_duty_r", int'(bus.duty_r), 60);
    idle_cycles(128);
    count_high(nl, nr);
    check("pwm_l_high_60", nl, 60);
    check("pwm_r_high_60", nr, 60);

    // veer right -> steer left, then a short glitch that the filter must reject
    bus.track_state = 2'b10;
    wait_mode(2, 20, "fwd_to_steer_l");
    bus.track_state = 2'b01;
    idle_cycles(5);
    bus.track_state = 2'b10;
    idle_cycles(12);
    check("glitch_no_mode_change", int'(bus.mode), 2);
    idle_cycles(120);
    check("steer_duty_l", int'(bus.duty_l), 20);
    check("steer_duty_r", int'(bus.duty_r), 60);

    // lost -> search: left wheel decelerates before reversing
    bus.track_state = 2'b00;
    wait_mode(4, 20, "steer_to_search");
    check("search_dir_l_held", int'(bus.dir_l), 2);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.duty_l == 6'd0) break;
    end
    check("search_dir_l_at_zero", int'(bus.dir_l), 2);
    @(negedge clk);
    check("search_dir_l_rev", int'(bus.dir_l), 1);
    idle_cycles(120);
    check("search_duty_l", int'(bus.duty_l), 40);
    check("search_duty_r", int'(bus.duty_r), 40);
    check("search_dir_r", int'(bus.dir_r), 2);
    bus.track_state = 2'b11;
    wait_mode(1, 20, "search_to_fwd");
    idle_cycles(300);

    // search timeout -> stop, which only enable low can leave
    bus.track_state = 2'b00;
    wait_mode(4, 20, "fwd_to_search");
    wait_mode(5, 400, "search_timeout_stop");
    idle_cycles(150);
    check("stop_duties", int'(bus.duty_l) + int'(bus.duty_r), 0);
    check("stop_dirs", int'({bus.dir_l, bus.dir_r}), 0);
    bus.track_state = 2'b11;
    idle_cycles(30);
    check("stop_sticky", int'(bus.mode), 5);
    bus.enable = 1'b0;
    wait_mode(0, 5, "stop_to_idle");

    // enable drop at full speed decelerates to zero, then pin goes quiet
    bus.enable = 1'b1;
    idle_cycles(300);
    check("refwd_duty_l", int'(bus.duty_l), 60);
    bus.enable = 1'b0;
    wait_mode(0, 5, "disable_to_idle");
    collect_duty_l(8, 200);
    for (int i = 0; i < 8; i++) check("ramp_down_step", (i < dq.size()) ? dq[i] : -1, exp_down[i]);
    idle_cycles(130);
    count_high(nl, nr);
    check("pwm_l_quiet", nl, 0);
    check("dir_l_coast", int'(bus.dir_l), 0);

    // asynchronous reset in the middle of a ramp
    bus.enable = 1'b1;
    idle_cycles(100);
    check("pre_reset_running", (bus.duty_l != 6'd0) ? 1 : 0, 1);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", int'(dut_vec()), 0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
